// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes, FSM states and pattern helpers
// for the two-street traffic safety monitor.
package traffic_pkg;

  // Lamp vectors: [2]=green, [1]=yellow, [0]=red
  localparam logic [2:0] LAMP_G   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_R   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Fault codes reported on fault_code
  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_ENCODING = 2'd1;
  localparam logic [1:0] FC_CONFLICT = 2'd2;
  localparam logic [1:0] FC_SEQUENCE = 2'd3;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    PASS    = 2'd1,
    FLASH   = 2'd2
  } state_e;

  // True when exactly one lamp of the vector is lit
  function automatic logic is_onehot(input logic [2:0] v);
    case (v)
      LAMP_G, LAMP_Y, LAMP_R: is_onehot = 1'b1;
      default:                is_onehot = 1'b0;
    endcase
  endfunction

  // True for the only permitted colour steps: G->Y, Y->R, R->G
  function automatic logic step_ok(input logic [2:0] prev_v, input logic [2:0] cur_v);
    step_ok = ((prev_v == LAMP_G) && (cur_v == LAMP_Y)) ||
              ((prev_v == LAMP_Y) && (cur_v == LAMP_R)) ||
              ((prev_v == LAMP_R) && (cur_v == LAMP_G));
  endfunction

endpackage

// File: rtl/traffic_safety_monitor_blink.sv
// Flashing-yellow phase generator. phase_on is the phase the lamps must
// show in the cycle after the coming clock edge, so the parent can register
// its lamp outputs from it with no extra latency. While enable is low the
// generator idles in the "on" phase, so a new flash always starts lit.
module lamp_blink_gen
  import traffic_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic phase_on
);

  localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt_q;
  logic          on_q;

  // Look-ahead phase for the next cycle
  always_comb begin
    if (!enable) begin
      phase_on = 1'b1;
    end else if (cnt_q == C_LAST) begin
      phase_on = !on_q;
    end else begin
      phase_on = on_q;
    end
  end

  // Half-period counter; toggles the phase every BLINK_HALF enabled cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      on_q  <= 1'b1;
    end else if (!enable) begin
      cnt_q <= '0;
      on_q  <= 1'b1;
    end else if (cnt_q == C_LAST) begin
      cnt_q <= '0;
      on_q  <= !on_q;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      on_q  <= on_q;
    end
  end

endmodule

// File: rtl/traffic_safety_monitor.sv
// Safety monitor behind the traffic light controller: passes legal lamp
// patterns through with one cycle of latency, filters short glitches, and
// on a confirmed violation latches a fault and flashes yellow on both
// streets until software clears it.
module traffic_safety_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned STARTUP_CYC   = 4,
  parameter int unsigned FAULT_CONFIRM = 2,
  parameter int unsigned BLINK_HALF    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] street_a_in,
  input  logic [2:0] street_b_in,
  input  logic       clear_fault,
  output logic [2:0] lamp_a,
  output logic [2:0] lamp_b,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int unsigned ST_W = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
  localparam int unsigned VC_W = $clog2(FAULT_CONFIRM + 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STARTUP_CYC - 1);
  localparam logic [VC_W-1:0] VC_MAX  = VC_W'(FAULT_CONFIRM);

  state_e          state_q;
  logic [ST_W-1:0] st_cnt_q;
  logic [VC_W-1:0] viol_cnt_q;
  logic [VC_W-1:0] viol_cnt_d;
  logic [2:0]      prev_a_q;
  logic [2:0]      prev_b_q;
  logic            first_q;
  logic [2:0]      lamp_a_q;
  logic [2:0]      lamp_b_q;
  logic            fault_q;
  logic [1:0]      code_q;

  logic            conflict_s;
  logic            encoding_s;
  logic            seq_a_s;
  logic            seq_b_s;
  logic            sequence_s;
  logic            violation_s;
  logic [1:0]      code_s;
  logic            phase_on_s;

  lamp_blink_gen #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (state_q == FLASH),
    .phase_on (phase_on_s)
  );

  // Classify the current inputs; conflict outranks encoding outranks sequence
  always_comb begin
    conflict_s  = (street_a_in[0] == 1'b0) && (street_b_in[0] == 1'b0);
    encoding_s  = !is_onehot(street_a_in) || !is_onehot(street_b_in);
    seq_a_s     = is_onehot(street_a_in) && (street_a_in != prev_a_q) &&
                  !step_ok(prev_a_q, street_a_in);
    seq_b_s     = is_onehot(street_b_in) && (street_b_in != prev_b_q) &&
                  !step_ok(prev_b_q, street_b_in);
    // The first PASS cycle has no trusted history to compare against
    sequence_s  = !first_q && (seq_a_s || seq_b_s);
    violation_s = conflict_s || encoding_s || sequence_s;
    if (conflict_s) begin
      code_s = FC_CONFLICT;
    end else if (encoding_s) begin
      code_s = FC_ENCODING;
    end else if (sequence_s) begin
      code_s = FC_SEQUENCE;
    end else begin
      code_s = FC_NONE;
    end
    if (viol_cnt_q == VC_MAX) begin
      viol_cnt_d = VC_MAX;
    end else begin
      viol_cnt_d = viol_cnt_q + VC_W'(1);
    end
  end

  // Monitor FSM with registered lamp, fault and code outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= STARTUP;
      st_cnt_q   <= '0;
      viol_cnt_q <= '0;
      prev_a_q   <= LAMP_R;
      prev_b_q   <= LAMP_R;
      first_q    <= 1'b1;
      lamp_a_q   <= LAMP_R;
      lamp_b_q   <= LAMP_R;
      fault_q    <= 1'b0;
      code_q     <= FC_NONE;
    end else begin
      case (state_q)
        STARTUP: begin
          lamp_a_q   <= LAMP_R;
          lamp_b_q   <= LAMP_R;
          viol_cnt_q <= '0;
          if (st_cnt_q == ST_LAST) begin
            state_q  <= PASS;
            st_cnt_q <= '0;
            prev_a_q <= street_a_in;
            prev_b_q <= street_b_in;
            first_q  <= 1'b1;
          end else begin
            st_cnt_q <= st_cnt_q + ST_W'(1);
          end
        end
        PASS: begin
          first_q <= 1'b0;
          if (violation_s) begin
            if (viol_cnt_d == VC_MAX) begin
              state_q    <= FLASH;
              fault_q    <= 1'b1;
              code_q     <= code_s;
              viol_cnt_q <= '0;
              lamp_a_q   <= phase_on_s ? LAMP_Y : LAMP_OFF;
              lamp_b_q   <= phase_on_s ? LAMP_Y : LAMP_OFF;
            end else begin
              viol_cnt_q <= viol_cnt_d;
            end
          end else begin
            lamp_a_q   <= street_a_in;
            lamp_b_q   <= street_b_in;
            prev_a_q   <= street_a_in;
            prev_b_q   <= street_b_in;
            viol_cnt_q <= '0;
          end
        end
        FLASH: begin
          viol_cnt_q <= '0;
          // Only release into a restart when the inputs are at least sane
          if (clear_fault && !conflict_s && !encoding_s) begin
            state_q  <= STARTUP;
            st_cnt_q <= '0;
            fault_q  <= 1'b0;
            code_q   <= FC_NONE;
            lamp_a_q <= LAMP_R;
            lamp_b_q <= LAMP_R;
          end else begin
            lamp_a_q <= phase_on_s ? LAMP_Y : LAMP_OFF;
            lamp_b_q <= phase_on_s ? LAMP_Y : LAMP_OFF;
          end
        end
        default: begin
          state_q  <= STARTUP;
          st_cnt_q <= '0;
          lamp_a_q <= LAMP_R;
          lamp_b_q <= LAMP_R;
        end
      endcase
    end
  end

  assign lamp_a     = lamp_a_q;
  assign lamp_b     = lamp_b_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Directed, table-driven bench for traffic_safety_monitor with the default
// parameters (STARTUP_CYC=4, FAULT_CONFIRM=2, BLINK_HALF=3).
module tb_traffic_safety_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] street_a_in;
  logic [2:0] street_b_in;
  logic       clear_fault;
  logic [2:0] lamp_a;
  logic [2:0] lamp_b;
  logic       fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       clr;
    logic [2:0] ea;
    logic [2:0] eb;
    logic       ef;
    logic [1:0] ec;
  } vec_t;

  vec_t vecs[$];

  traffic_safety_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .street_a_in (street_a_in),
    .street_b_in (street_b_in),
    .clear_fault (clear_fault),
    .lamp_a      (lamp_a),
    .lamp_b      (lamp_b),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [2:0] a, input logic [2:0] b, input logic clr,
                     input logic [2:0] ea, input logic [2:0] eb,
                     input logic ef, input logic [1:0] ec);
    vec_t v;
    v.a = a; v.b = b; v.clr = clr; v.ea = ea; v.eb = eb; v.ef = ef; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] ea, input logic [2:0] eb,
                       input logic ef, input logic [1:0] ec);
    checks++;
    if (lamp_a !== ea || lamp_b !== eb || fault !== ef || fault_code !== ec) begin
      errors++;
      $display("FAIL %s: got a=%b b=%b fault=%b code=%0d, expected a=%b b=%b fault=%b code=%0d",
               name, lamp_a, lamp_b, fault, fault_code, ea, eb, ef, ec);
    end
  endtask

  initial begin
    // Reset release and STARTUP (vectors 1-4), first PASS output (5)
    for (int i = 0; i < 4; i++) add(3'b100, 3'b001, 1'b0, 3'b001, 3'b001, 1'b0, 2'd0);
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0);
    // One-cycle conflict is filtered; two cycles latch conflict fault
    add(3'b100, 3'b100, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0);
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0);
    add(3'b100, 3'b100, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0);
    add(3'b100, 3'b100, 1'b0, 3'b010, 3'b010, 1'b1, 2'd2);
    // Blink: on 3 cycles, off 3, on again; clears blocked by conflict/encoding
    add(3'b100, 3'b100, 1'b0, 3'b010, 3'b010, 1'b1, 2'd2);
    add(3'b100, 3'b100, 1'b0, 3'b010, 3'b010, 1'b1, 2'd2);
    add(3'b100, 3'b100, 1'b0, 3'b000, 3'b000, 1'b1, 2'd2);
    add(3'b100, 3'b100, 1'b1, 3'b000, 3'b000, 1'b1, 2'd2);
    add(3'b110, 3'b001, 1'b1, 3'b000, 3'b000, 1'b1, 2'd2);
    add(3'b100, 3'b100, 1'b0, 3'b010, 3'b010, 1'b1, 2'd2);
    // Accepted clear, then 4 STARTUP cycles ignoring garbage inputs
    add(3'b001, 3'b100, 1'b1, 3'b001, 3'b001, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) add(3'b111, 3'b000, 1'b0, 3'b001, 3'b001, 1'b0, 2'd0);
    add(3'b100, 3'b001, 1'b0, 3'b001, 3'b001, 1'b0, 2'd0);
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0);
    // Legal G->Y->R->G (clear_fault in PASS ignored), then illegal G->R
    add(3'b010, 3'b001, 1'b1, 3'b010, 3'b001, 1'b0, 2'd0);
    add(3'b001, 3'b001, 1'b0, 3'b001, 3'b001, 1'b0, 2'd0);
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0);
    add(3'b001, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0);
    add(3'b001, 3'b001, 1'b0, 3'b010, 3'b010, 1'b1, 2'd3);
    add(3'b001, 3'b001, 1'b1, 3'b001, 3'b001, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) add(3'b100, 3'b001, 1'b0, 3'b001, 3'b001, 1'b0, 2'd0);
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0);
    // All-off encoding fault
    add(3'b000, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0);
    add(3'b000, 3'b001, 1'b0, 3'b010, 3'b010, 1'b1, 2'd1);
    add(3'b100, 3'b001, 1'b1, 3'b001, 3'b001, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) add(3'b100, 3'b001, 1'b0, 3'b001, 3'b001, 1'b0, 2'd0);
    // First PASS cycle skips the sequence check (G->R accepted), then multi-hot
    add(3'b001, 3'b001, 1'b0, 3'b001, 3'b001, 1'b0, 2'd0);
    add(3'b110, 3'b001, 1'b0, 3'b001, 3'b001, 1'b0, 2'd0);
    add(3'b110, 3'b001, 1'b0, 3'b010, 3'b010, 1'b1, 2'd1);
    add(3'b100, 3'b001, 1'b1, 3'b001, 3'b001, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) add(3'b100, 3'b001, 1'b0, 3'b001, 3'b001, 1'b0, 2'd0);
    add(3'b100, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0);
    // Class change keeps counting; conflict outranks encoding in the code
    add(3'b110, 3'b001, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0);
    add(3'b000, 3'b000, 1'b0, 3'b010, 3'b010, 1'b1, 2'd2);

    // Reset
    rst_n       = 1'b0;
    street_a_in = 3'b100;
    street_b_in = 3'b001;
    clear_fault = 1'b0;
    tick();
    tick();
    check("reset", 3'b001, 3'b001, 1'b0, 2'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      street_a_in = vecs[i].a;
      street_b_in = vecs[i].b;
      clear_fault = vecs[i].clr;
      tick();
      check($sformatf("vec%0d", i + 1), vecs[i].ea, vecs[i].eb, vecs[i].ef, vecs[i].ec);
    end
    clear_fault = 1'b0;

    // Still flashing, then reset mid-FLASH dominates a simultaneous clear
    tick();
    check("flash_hold", 3'b010, 3'b010, 1'b1, 2'd2);
    rst_n       = 1'b0;
    clear_fault = 1'b1;
    street_a_in = 3'b100;
    street_b_in = 3'b100;
    tick();
    check("reset_mid_flash", 3'b001, 3'b001, 1'b0, 2'd0);
    rst_n       = 1'b0;
    rst_n       = 1'b1;
    clear_fault = 1'b0;
    street_a_in = 3'b100;
    street_b_in = 3'b001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("restart_red%0d", i + 1), 3'b001, 3'b001, 1'b0, 2'd0);
    end
    tick();
    check("restart_pass", 3'b100, 3'b001, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_safety_monitor.md
Name: traffic_safety_monitor

Overview:
- Downstream stage of the two-street traffic light controller.
- Consumes the controller's per-street lamp vectors and checks them every cycle for illegal patterns: both streets non-red, not one-hot, or an illegal colour step.
- While the inputs are legal, it drives the physical lamp outputs from them.
- On a confirmed violation, it latches a fault and forces both streets to flashing yellow until software clears it.

Parameters:
- STARTUP_CYC, 4: cycles of forced all-red after reset or after a fault clear.
- FAULT_CONFIRM, 2: consecutive violating cycles needed to latch a fault (glitch filter); legal range 1..15.
- BLINK_HALF, 3: cycles per half-period of the flashing yellow.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- street_a_in  in  3  controller lamp vector, street A; [2]=green, [1]=yellow, [0]=red.
- street_b_in  in  3  controller lamp vector, street B; same encoding.
- clear_fault  in  1  single-cycle pulse; requests exit from the fault state.
- lamp_a  out  3  registered lamp drive, street A; same encoding.
- lamp_b  out  3  registered lamp drive, street B.
- fault  out  1  high while a fault is latched.
- fault_code  out  2  0=none, 1=encoding, 2=conflict, 3=sequence.

Behaviour:
- Reset (rst_n=0 at a rising edge), regardless of state:
  - state=STARTUP, lamp_a=lamp_b=3'b001, fault=0, fault_code=0.
  - All counters are cleared.
- STARTUP:
  - Lamps are red/red; inputs are ignored.
  - Stays here for STARTUP_CYC cycles after rst_n rises or after the state is entered.
  - On the last cycle, prev_a/prev_b load the current inputs, then the state goes to PASS.
  - No sequence check is applied to the first PASS cycle.
- PASS, violation classes evaluated combinationally on the current inputs, priority conflict > encoding > sequence:
  - conflict: street_a_in[0]==0 and street_b_in[0]==0 (neither street shows red).
  - encoding: either input is not exactly one-hot (000 or multi-hot).
  - sequence: an input is one-hot and differs from its prev_x, and the step is not one of G->Y, Y->R, R->G.
- PASS, legal cycle:
  - lamp_x <= street_x_in (1-cycle latency).
  - prev_x <= street_x_in.
  - The violation counter clears.
- PASS, violating cycle:
  - lamp_x and prev_x hold their last legal value.
  - The violation counter increments.
  - A class change between consecutive violating cycles does not reset the counter.
  - On the cycle the counter reaches FAULT_CONFIRM, the state goes to FLASH next edge, fault<=1 and fault_code<=the code of that cycle.
- FLASH:
  - lamp_a=lamp_b=3'b010 for BLINK_HALF cycles, then 3'b000 for BLINK_HALF cycles, repeating.
  - The on-phase starts on the first FLASH cycle.
  - fault_code holds its value.
  - clear_fault with current inputs free of conflict and encoding violations: the state goes to STARTUP, and fault and fault_code clear on the same edge.
  - clear_fault while either of those violations is present is ignored (the state stays FLASH).
  - clear_fault outside FLASH is ignored.
- Simultaneous events:
  - rst_n low dominates clear_fault and all violations.
  - A violation on the clearing cycle is not counted.
- Counters: widths are from $clog2 of the parameters and saturate at the terminal value; there is no wrap.

Decomposition:
- Package traffic_pkg holds:
  - Lamp encodings: LAMP_G=3'b100, LAMP_Y=3'b010, LAMP_R=3'b001, LAMP_OFF=3'b000.
  - Fault code constants.
  - The state enum {STARTUP, PASS, FLASH}.
- One sub-module, lamp_blink_gen:
  - Parameter BLINK_HALF; inputs clk, rst_n, enable.
  - Output phase_on, which restarts high on the rising edge of enable.

Test Plan (defaults):
1. Reset release; inputs A=100, B=001 -> lamps 001/001 for 4 cycles; then lamp_a=100, lamp_b=001 one cycle after the inputs are sampled; fault=0.
2. From A=100, B=001: drive A=100, B=100 for 1 cycle, then back -> no fault, lamps hold 100/001. The same violation held for 2 cycles -> fault=1, fault_code=2, lamps 010/010 for 3 cycles, 000/000 for 3 cycles, repeating.
3. A=000 for 2 cycles with B=001 -> fault_code=1. A=110 for 2 cycles -> fault_code=1.
4. A steps 100->010->001 with B=001 -> no fault. Separately, A steps 100->001 and holds 2 cycles -> fault_code=3.
5. In FLASH with inputs 100/100, pulse clear_fault -> stays FLASH. Inputs 001/100, pulse clear_fault -> fault=0, fault_code=0, lamps 001/001 for 4 cycles, then PASS.
6. rst_n=0 for one edge mid-FLASH -> next cycle lamps 001/001, fault=0, STARTUP restarts its 4-cycle count.
